// File: rtl/voting_pkg.sv
// Shared definitions for the voting machine: poll states, default sizes, vote encoding.
package voting_pkg;

    localparam int unsigned N_VOTERS_DEF = 4;
    localparam int unsigned ID_W_DEF     = 2;

    localparam logic VOTE_YES = 1'b1;
    localparam logic VOTE_NO  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PRESENT = 2'd2
    } poll_state_e;

endpackage

// File: rtl/poll_timer.sv
// Saturating cycle counter with clear/enable; flags the last cycle before TIMEOUT_CYCLES elapse.
module poll_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);
    localparam int unsigned CNT_W  = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TC_VAL = TO_EN ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(TC_VAL);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        tc_c = TO_EN && (cnt_q == CNT_TC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ballot_collector.sv
// Poll front end: opens a poll, collects one vote per voter, presents the ballot to the tally stage.
module ballot_collector
    import voting_pkg::*;
#(
    parameter int unsigned N_VOTERS       = N_VOTERS_DEF,
    parameter int unsigned ID_W           = ID_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                open_poll,
    input  logic                close_poll,
    input  logic                vote_valid,
    input  logic [ID_W-1:0]     vote_id,
    input  logic                vote_val,
    output logic                vote_ready,
    output logic                vote_reject,
    output logic [N_VOTERS-1:0] voted,
    output logic [N_VOTERS-1:0] ballot,
    output logic                ballot_valid,
    input  logic                ballot_ack,
    output logic                poll_open
);

    poll_state_e         state_q, state_d;
    logic [N_VOTERS-1:0] voted_q, voted_d;
    logic [N_VOTERS-1:0] ballot_q, ballot_d;
    logic                vote_ready_q, vote_ready_d;
    logic                vote_reject_q, vote_reject_d;
    logic                ballot_valid_q, ballot_valid_d;
    logic                poll_open_q, poll_open_d;

    logic timer_clr_c, timer_en_c, timeout_c;
    logic handshake_c, id_ok_c;

    poll_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_poll_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr_c),
        .en   (timer_en_c),
        .tc_c (timeout_c)
    );

    // Close test uses voted_d so a completing vote and the close land on the same edge.
    always_comb begin
        state_d       = state_q;
        voted_d       = voted_q;
        ballot_d      = ballot_q;
        vote_reject_d = 1'b0;
        timer_clr_c   = 1'b0;
        timer_en_c    = (state_q == ST_COLLECT);
        handshake_c   = vote_valid && vote_ready_q;
        id_ok_c       = ({1'b0, vote_id} < (ID_W + 1)'(N_VOTERS));

        case (state_q)
            ST_IDLE: begin
                if (open_poll) begin
                    state_d     = ST_COLLECT;
                    voted_d     = '0;
                    ballot_d    = '0;
                    timer_clr_c = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (handshake_c) begin
                    if (id_ok_c && !voted_q[vote_id]) begin
                        voted_d[vote_id]  = 1'b1;
                        ballot_d[vote_id] = vote_val;
                    end else begin
                        vote_reject_d = 1'b1;
                    end
                end
                if ((&voted_d) || close_poll || timeout_c) begin
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (ballot_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        vote_ready_d   = (state_d == ST_COLLECT);
        poll_open_d    = (state_d == ST_COLLECT);
        ballot_valid_d = (state_d == ST_PRESENT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            voted_q        <= '0;
            ballot_q       <= '0;
            vote_ready_q   <= 1'b0;
            vote_reject_q  <= 1'b0;
            ballot_valid_q <= 1'b0;
            poll_open_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            voted_q        <= voted_d;
            ballot_q       <= ballot_d;
            vote_ready_q   <= vote_ready_d;
            vote_reject_q  <= vote_reject_d;
            ballot_valid_q <= ballot_valid_d;
            poll_open_q    <= poll_open_d;
        end
    end

    assign vote_ready   = vote_ready_q;
    assign vote_reject  = vote_reject_q;
    assign voted        = voted_q;
    assign ballot       = ballot_q;
    assign ballot_valid = ballot_valid_q;
    assign poll_open    = poll_open_q;

endmodule

// File: tb/tb_ballot_collector.sv
// Directed and random stimulus for ballot_collector, checked every cycle against a poll-level model.
module tb_ballot_collector;

    localparam int unsigned NV = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst, open_poll, close_poll, vote_valid, vote_val, ballot_ack;
    logic [IW-1:0] vote_id;
    logic          vote_ready, vote_reject, ballot_valid, poll_open;
    logic [NV-1:0] voted, ballot;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: which part of the poll we are in, who voted and how, cycles spent collecting.
    int          m_phase = 0;  // 0 idle, 1 collecting, 2 presenting
    bit          m_voted [NV];
    bit          m_ballot[NV];
    int          m_cycles = 0;
    bit          m_reject = 0;

    ballot_collector #(
        .N_VOTERS(NV), .ID_W(IW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .open_poll(open_poll), .close_poll(close_poll),
        .vote_valid(vote_valid), .vote_id(vote_id), .vote_val(vote_val),
        .vote_ready(vote_ready), .vote_reject(vote_reject), .voted(voted),
        .ballot(ballot), .ballot_valid(ballot_valid), .ballot_ack(ballot_ack),
        .poll_open(poll_open)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NV-1:0] pack(input bit a[NV]);
        logic [NV-1:0] v;
        for (int i = 0; i < NV; i++) v[i] = a[i];
        return v;
    endfunction

    task automatic model_edge(input bit r, input bit op, input bit cl, input bit vv,
                              input int id, input bit vl, input bit ak);
        bit all_in;
        m_reject = 0;
        if (r) begin
            m_phase = 0; m_cycles = 0;
            for (int i = 0; i < NV; i++) begin m_voted[i] = 0; m_ballot[i] = 0; end
        end else if (m_phase == 0) begin
            if (op) begin
                m_phase = 1; m_cycles = 0;
                for (int i = 0; i < NV; i++) begin m_voted[i] = 0; m_ballot[i] = 0; end
            end
        end else if (m_phase == 1) begin
            if (vv) begin
                if (id < NV && !m_voted[id]) begin
                    m_voted[id] = 1; m_ballot[id] = vl;
                end else begin
                    m_reject = 1;
                end
            end
            m_cycles++;
            all_in = 1;
            for (int i = 0; i < NV; i++) if (!m_voted[i]) all_in = 0;
            if (all_in || cl || m_cycles >= TO) m_phase = 2;
        end else begin
            if (ak) m_phase = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ready"},  32'(vote_ready),   32'(m_phase == 1));
        chk({tag, ".open"},   32'(poll_open),    32'(m_phase == 1));
        chk({tag, ".valid"},  32'(ballot_valid), 32'(m_phase == 2));
        chk({tag, ".reject"}, 32'(vote_reject),  32'(m_reject));
        chk({tag, ".voted"},  32'(voted),        32'(pack(m_voted)));
        chk({tag, ".ballot"}, 32'(ballot),       32'(pack(m_ballot)));
    endtask

    task automatic step(input string tag, input bit r, input bit op, input bit cl,
                        input bit vv, input int id, input bit vl, input bit ak);
        rst = r; open_poll = op; close_poll = cl; vote_valid = vv;
        vote_id = IW'(id); vote_val = vl; ballot_ack = ak;
        @(posedge clk);
        model_edge(r, op, cl, vv, id, vl, ak);
        #1;
        check_all(tag);
    endtask

    task automatic idle_step(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; open_poll = 0; close_poll = 0; vote_valid = 0;
        vote_id = '0; vote_val = 0; ballot_ack = 0;
        for (int i = 0; i < NV; i++) begin m_voted[i] = 0; m_ballot[i] = 0; end

        step("reset", 1, 0, 0, 0, 0, 0, 0);
        chk("reset.all", 32'({vote_ready, vote_reject, voted, ballot, ballot_valid, poll_open}), 32'd0);

        // Full poll
        step("full.open", 0, 1, 0, 0, 0, 0, 0);
        step("full.v0", 0, 0, 0, 1, 0, 1, 0);
        step("full.v1", 0, 0, 0, 1, 1, 0, 0);
        step("full.v2", 0, 0, 0, 1, 2, 1, 0);
        step("full.v3", 0, 0, 0, 1, 3, 1, 0);
        chk("full.ballot", 32'(ballot), 32'h0000000d);
        chk("full.voted", 32'(voted), 32'h0000000f);
        chk("full.valid", 32'(ballot_valid), 32'd1);
        idle_step("full.hold");
        step("full.ack", 0, 0, 0, 0, 0, 0, 1);
        chk("full.idle", 32'(ballot_valid), 32'd0);

        // Duplicate vote
        step("dup.open", 0, 1, 0, 0, 0, 0, 0);
        step("dup.v2a", 0, 0, 0, 1, 2, 1, 0);
        step("dup.v2b", 0, 0, 0, 1, 2, 0, 0);
        chk("dup.reject", 32'(vote_reject), 32'd1);
        step("dup.close", 0, 0, 1, 0, 0, 0, 0);
        chk("dup.reject_drop", 32'(vote_reject), 32'd0);
        chk("dup.ballot", 32'(ballot), 32'h00000004);
        step("dup.ack", 0, 0, 0, 0, 0, 0, 1);

        // Early close with simultaneous vote
        step("ecl.open", 0, 1, 0, 0, 0, 0, 0);
        step("ecl.v0", 0, 0, 0, 1, 0, 1, 0);
        step("ecl.v3close", 0, 0, 1, 1, 3, 1, 0);
        chk("ecl.ballot", 32'(ballot), 32'h00000009);
        chk("ecl.voted", 32'(voted), 32'h00000009);
        chk("ecl.valid", 32'(ballot_valid), 32'd1);

        // Backpressure in PRESENT
        for (int i = 0; i < 5; i++) step("bp.hold", 0, 1, 1, 1, i % NV, 0, 0);
        chk("bp.ballot", 32'(ballot), 32'h00000009);
        chk("bp.reject", 32'(vote_reject), 32'd0);
        step("bp.ack", 0, 0, 0, 0, 0, 0, 1);

        // Timeout: PRESENT exactly TO cycles after entering COLLECT
        step("to.open", 0, 1, 0, 0, 0, 0, 0);
        step("to.v1", 0, 0, 0, 1, 1, 1, 0);
        for (int i = 0; i < TO - 2; i++) idle_step("to.wait");
        chk("to.not_yet", 32'(ballot_valid), 32'd0);
        idle_step("to.expire");
        chk("to.valid", 32'(ballot_valid), 32'd1);
        chk("to.ballot", 32'(ballot), 32'h00000002);
        step("to.ack", 0, 0, 0, 0, 0, 0, 1);

        // Reset mid-poll
        step("rmp.open", 0, 1, 0, 0, 0, 0, 0);
        step("rmp.v0", 0, 0, 0, 1, 0, 1, 0);
        step("rmp.v1", 0, 0, 0, 1, 1, 1, 0);
        step("rmp.rst", 1, 0, 0, 0, 0, 0, 0);
        chk("rmp.all", 32'({vote_ready, vote_reject, voted, ballot, ballot_valid, poll_open}), 32'd0);
        step("rmp.reopen", 0, 1, 0, 0, 0, 0, 0);
        chk("rmp.clean", 32'({voted, ballot}), 32'd0);
        chk("rmp.open", 32'(poll_open), 32'd1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step("rnd",
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 1) == 0),
                 int'($urandom_range(0, NV - 1)),
                 bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
